// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared types and truth-table constants for the gate truth-table checker
package gate_tt_pkg;

    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Truth tables indexed by {a,b}: bit i is the expected y for combination i.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_tt_settle_ctr.sv
// rtl/gate_tt_settle_ctr.sv - saturating settle counter with clear-load and terminal-count flag
module gate_tt_settle_ctr #(
    parameter int              WIDTH    = 4,
    parameter logic [WIDTH-1:0] TERMINAL = 4'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] count;

    // Load returns the count to zero; counting stops at TERMINAL so tc stays asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && (count != TERMINAL)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/gate_tt_checker.sv
// rtl/gate_tt_checker.sv - drives all {a,b} combinations into a 2-input gate and checks y against a truth table
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] expect_tt,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [3:0]       tt_q;
    logic             settle_tc;
    logic             mismatch;
    logic [3:0]       mask_next;

    // The counter only runs in APPLY; every other state holds it at zero so each
    // combination starts its settle window from 0.
    gate_tt_settle_ctr #(
        .WIDTH    (4),
        .TERMINAL (SETTLE_LAST)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state != ST_APPLY),
        .en    (state == ST_APPLY),
        .tc    (settle_tc)
    );

    assign mismatch  = (y != tt_q[idx]);
    assign mask_next = fail_mask | (4'(mismatch) << idx);

    // Run-control FSM; all outputs are registered so a/b are glitch-free into the gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            tt_q      <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        tt_q      <= expect_tt;
                        idx       <= '0;
                        fail_mask <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        state     <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (settle_tc) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    fail_mask <= mask_next;
                    if (idx == 2'd3) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= ~|mask_next;
                        a     <= 1'b0;
                        b     <= 1'b0;
                    end else begin
                        idx    <= idx + 2'd1;
                        {a, b} <= idx + 2'd1;
                        state  <= ST_APPLY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb/tb_gate_tt_checker.sv - scoreboard bench for gate_tt_checker with a behavioural gate model
module tb_gate_tt_checker;
    import gate_tt_pkg::*;

    localparam int S   = 2;
    localparam int P   = S + 1;
    localparam int RUN = 4 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] expect_tt = 4'b0000;
    logic       a, b, y, busy, done, pass;
    logic [3:0] fail_mask;
    logic [3:0] gut_tt = TT_NAND;

    logic       start1 = 1'b0;
    logic [3:0] expect1 = 4'b0000;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [3:0] fail_mask1;
    logic [3:0] gut1 = TT_NAND;

    assign y  = gut_tt[{a, b}];
    assign y1 = gut1[{a1, b1}];

    gate_tt_checker #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expect_tt(expect_tt),
        .a(a), .b(b), .y(y), .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask)
    );

    gate_tt_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expect_tt(expect1),
        .a(a1), .b(b1), .y(y1), .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fail_mask1)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int         n;
        logic [3:0] mask;
    } run_t;
    run_t sb[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    int k;
    // Monitor: checks the per-cycle drive pattern and the final verdict of the run at the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0) begin
                k = edge_n - sb[0].n;
                if (k < RUN) begin
                    chk("ab_seq", int'({a, b}), k / P);
                    chk("busy_run", int'(busy), 1);
                    chk("done_run", int'(done), 0);
                    chk("mask_partial", int'(fail_mask), int'(sb[0].mask) & ((1 << (k / P)) - 1));
                end else begin
                    chk("done_cycle", int'(done), 1);
                    chk("busy_done", int'(busy), 0);
                    chk("mask_final", int'(fail_mask), int'(sb[0].mask));
                    chk("pass_final", int'(pass), int'(sb[0].mask == 4'b0000));
                    chk("ab_done", int'({a, b}), 0);
                    void'(sb.pop_front());
                end
            end else begin
                chk("ab_idle", int'({a, b}), 0);
                chk("busy_idle", int'(busy), 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic run_start(input logic [3:0] tt, input bit push);
        expect_tt = tt;
        start = 1'b1;
        if (push) sb.push_back(run_t'{n: edge_n + 1, mask: tt ^ gut_tt});
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 100) begin
            tick();
            t++;
        end
        chk("run_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run1(input logic [3:0] tt);
        int n;
        int t;
        expect1 = tt;
        start1 = 1'b1;
        n = edge_n + 1;
        tick();
        start1 = 1'b0;
        chk("s1_done_clear", int'(done1), 0);
        t = 0;
        while (!done1 && t < 50) begin
            tick();
            t++;
        end
        chk("s1_latency", edge_n - n, 8);
        chk("s1_mask", int'(fail_mask1), int'(tt ^ gut1));
        chk("s1_pass", int'(pass1), int'((tt ^ gut1) == 4'b0000));
    endtask

    logic [3:0] gates [6];

    initial begin
        gates = '{TT_AND, TT_NAND, TT_OR, TT_NOR, TT_XOR, TT_XNOR};
        repeat (2) tick();
        chk("rst_a", int'(a), 0);
        chk("rst_b", int'(b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_mask", int'(fail_mask), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        gut_tt = TT_NAND;  run_start(TT_NAND, 1); wait_done();
        gut_tt = 4'b1111;  run_start(TT_NAND, 1); wait_done();
        gut_tt = TT_NAND;  run_start(TT_XOR, 1);  wait_done();

        // Start during APPLY of idx 2 with a different table must be ignored.
        run_start(TT_NAND, 1);
        repeat (2 * P) tick();
        run_start(4'b0000, 0);
        wait_done();

        // Asynchronous reset while idx 1 is being applied.
        run_start(TT_NAND, 1);
        repeat (P) tick();
        chk("pre_rst_b", int'(b), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_a", int'(a), 0);
        chk("arst_b", int'(b), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_mask", int'(fail_mask), 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle_done", int'(done), 0);
        run_start(TT_NAND, 1); wait_done();

        // Back-to-back restart in the cycle done is observed.
        gut_tt = TT_XNOR;  run_start(TT_XNOR, 1); wait_done();
        run_start(TT_OR, 1); wait_done();

        for (int i = 0; i < 10; i++) begin
            gut_tt = ($urandom_range(0, 3) == 0) ? 4'($urandom) : gates[$urandom_range(0, 5)];
            run_start(gates[$urandom_range(0, 5)], 1);
            wait_done();
            repeat ($urandom_range(0, 3)) tick();
        end

        // Minimum settle time, including a back-to-back restart.
        gut1 = TT_NAND; run1(TT_NAND);
        run1(TT_AND);
        gut1 = 4'b0000; run1(TT_NOR);

        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
